// File: rtl/psw_setter.sv
// Password programming block: enter a new 4-digit code, re-enter it to confirm,
// and commit it to the code register read by the lock checker.
`timescale 1ns/1ps
module psw_setter #(
   parameter logic [15:0] DEFAULT_CODE   = 16'h2016,
   parameter int          TIMEOUT_CYCLES = 50_000_000,
   parameter int          ERR_CYCLES     = 25_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [9:0]  sw,
   input  logic        prog_req,
   output logic [15:0] code,
   output logic        code_updated,
   output logic        busy,
   output logic [6:0]  HEX4,
   output logic [6:0]  HEX3,
   output logic [6:0]  HEX2,
   output logic [6:0]  HEX1,
   output logic [6:0]  HEX0
);
   localparam int TMAX = (TIMEOUT_CYCLES > ERR_CYCLES) ? TIMEOUT_CYCLES : ERR_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [6:0] BLANK  = 7'b1111111;
   localparam logic [6:0] DASH   = 7'b0111111;
   localparam logic [6:0] GLYPH_P = 7'b0001100;
   localparam logic [6:0] GLYPH_C = 7'b1000110;
   localparam logic [6:0] GLYPH_E = 7'b0000110;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ENTER   = 3'd1,
      CONFIRM = 3'd2,
      COMMIT  = 3'd3,
      ERR     = 3'd4
   } state_t;

   function automatic logic is_onehot(input logic [9:0] s);
      return (s != 10'd0) && ((s & (s - 10'd1)) == 10'd0);
   endfunction

   function automatic logic [3:0] sw_digit(input logic [9:0] s);
      logic [3:0] d;
      d = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (s[i]) d = 4'(i);
      end
      return d;
   endfunction

   function automatic logic [6:0] digit_glyph(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return BLANK;
      endcase
   endfunction

   state_t          state_r, state_nxt_s;
   logic [9:0]      sw_prev_r;
   logic [TW-1:0]   tmr_r;
   logic [1:0]      cnt_r;
   logic            mismatch_r;
   logic [3:0]      digits_r  [4];
   logic [6:0]      dig_hex_r [4];
   logic            press_s;
   logic [3:0]      digit_s;
   logic            diff_s;
   logic [6:0]      hex4_nxt_s;
   logic            busy_nxt_s;
   logic            upd_nxt_s;

   // A press is a one-hot switch pattern rising out of an all-zero bus.
   assign press_s = (sw_prev_r == 10'd0) && is_onehot(sw);
   assign digit_s = sw_digit(sw);
   assign diff_s  = (digit_s != digits_r[cnt_r]);

   assign HEX3 = dig_hex_r[0];
   assign HEX2 = dig_hex_r[1];
   assign HEX1 = dig_hex_r[2];
   assign HEX0 = dig_hex_r[3];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= IDLE;
      else        state_r <= state_nxt_s;
   end

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE:    if (prog_req) state_nxt_s = ENTER; else state_nxt_s = IDLE;
         ENTER: begin
            if (press_s) begin
               if (cnt_r == 2'd3) state_nxt_s = CONFIRM; else state_nxt_s = ENTER;
            end else if (tmr_r == TW'(TIMEOUT_CYCLES - 1)) begin
               state_nxt_s = ERR;
            end else begin
               state_nxt_s = ENTER;
            end
         end
         CONFIRM: begin
            if (press_s) begin
               if (cnt_r != 2'd3)          state_nxt_s = CONFIRM;
               else if (mismatch_r || diff_s) state_nxt_s = ERR;
               else                        state_nxt_s = COMMIT;
            end else if (tmr_r == TW'(TIMEOUT_CYCLES - 1)) begin
               state_nxt_s = ERR;
            end else begin
               state_nxt_s = CONFIRM;
            end
         end
         COMMIT:  state_nxt_s = IDLE;
         ERR:     if (tmr_r == TW'(ERR_CYCLES - 1)) state_nxt_s = IDLE; else state_nxt_s = ERR;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Output decode, taken from the next state so the registered outputs track state_r
   always_comb begin
      hex4_nxt_s = BLANK;
      case (state_nxt_s)
         ENTER:   hex4_nxt_s = GLYPH_P;
         CONFIRM: hex4_nxt_s = GLYPH_C;
         ERR:     hex4_nxt_s = GLYPH_E;
         default: hex4_nxt_s = BLANK;
      endcase
      busy_nxt_s = (state_nxt_s != IDLE);
      upd_nxt_s  = (state_r == COMMIT);
   end

   // Registered status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         HEX4         <= BLANK;
         busy         <= 1'b0;
         code_updated <= 1'b0;
      end else begin
         HEX4         <= hex4_nxt_s;
         busy         <= busy_nxt_s;
         code_updated <= upd_nxt_s;
      end
   end

   // Shared inactivity / error-hold timer, restarted on every state change
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmr_r     <= TW'(0);
         sw_prev_r <= 10'd0;
      end else begin
         sw_prev_r <= sw;
         if (state_nxt_s != state_r)                     tmr_r <= TW'(0);
         else if (state_r == ENTER || state_r == CONFIRM) tmr_r <= press_s ? TW'(0) : tmr_r + TW'(1);
         else if (state_r == ERR)                        tmr_r <= tmr_r + TW'(1);
         else                                            tmr_r <= TW'(0);
      end
   end

   // Digit buffer, display digits and committed code
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code       <= DEFAULT_CODE;
         cnt_r      <= 2'd0;
         mismatch_r <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            digits_r[i]  <= 4'd0;
            dig_hex_r[i] <= BLANK;
         end
      end else begin
         case (state_r)
            IDLE: begin
               if (prog_req) begin
                  cnt_r      <= 2'd0;
                  mismatch_r <= 1'b0;
                  for (int i = 0; i < 4; i++) begin
                     digits_r[i]  <= 4'd0;
                     dig_hex_r[i] <= BLANK;
                  end
               end
            end
            ENTER: begin
               if (press_s) begin
                  digits_r[cnt_r]  <= digit_s;
                  dig_hex_r[cnt_r] <= digit_glyph(digit_s);
                  cnt_r            <= cnt_r + 2'd1;
               end
               if (state_nxt_s != ENTER) begin
                  for (int i = 0; i < 4; i++) dig_hex_r[i] <= BLANK;
               end
            end
            CONFIRM: begin
               if (press_s) begin
                  if (diff_s) mismatch_r <= 1'b1;
                  dig_hex_r[cnt_r] <= DASH;
                  cnt_r            <= cnt_r + 2'd1;
               end
               if (state_nxt_s == ERR) begin
                  for (int i = 0; i < 4; i++) dig_hex_r[i] <= BLANK;
               end
            end
            COMMIT: begin
               code <= {digits_r[0], digits_r[1], digits_r[2], digits_r[3]};
               for (int i = 0; i < 4; i++) dig_hex_r[i] <= BLANK;
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_psw_setter.sv
// Directed bench for psw_setter with shortened timeout and error-hold periods.
`timescale 1ns/1ps
module tb_psw_setter;
   localparam int TMO  = 20;
   localparam int ERRC = 8;

   localparam logic [6:0] BL = 7'b1111111;
   localparam logic [6:0] DS = 7'b0111111;
   localparam logic [6:0] GP = 7'b0001100;
   localparam logic [6:0] GC = 7'b1000110;
   localparam logic [6:0] GE = 7'b0000110;
   localparam logic [6:0] G1 = 7'b1111001;
   localparam logic [6:0] G3 = 7'b0110000;
   localparam logic [6:0] G4 = 7'b0011001;
   localparam logic [6:0] G5 = 7'b0010010;
   localparam logic [6:0] G6 = 7'b0000010;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [9:0]  sw = 10'd0;
   logic        prog_req = 1'b0;
   logic [15:0] code;
   logic        code_updated, busy;
   logic [6:0]  HEX4, HEX3, HEX2, HEX1, HEX0;

   int checks = 0;
   int errors = 0;
   logic upd_seen;

   psw_setter #(.TIMEOUT_CYCLES(TMO), .ERR_CYCLES(ERRC)) dut (
      .clk(clk), .rst_n(rst_n), .sw(sw), .prog_req(prog_req),
      .code(code), .code_updated(code_updated), .busy(busy),
      .HEX4(HEX4), .HEX3(HEX3), .HEX2(HEX2), .HEX1(HEX1), .HEX0(HEX0)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input int d);
      sw = 10'd1 << d;
      tick();
      sw = 10'd0;
      tick();
   endtask

   task automatic start();
      prog_req = 1'b1;
      tick();
      prog_req = 1'b0;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      tick(); tick();
      check("rst_code", code, 16'h2016);
      check("rst_busy", busy, 1'b0);
      check("rst_upd", code_updated, 1'b0);
      check("rst_hex", {HEX4, HEX3, HEX2, HEX1, HEX0}, {5{BL}});
      rst_n = 1'b1;
      tick();

      // confirm mismatch: 1-2-3-4 then 1-2-3-5
      start();
      press(1); press(2); press(3); press(4);
      press(1); press(2); press(3);
      sw = 10'd1 << 5;
      tick();
      sw = 10'd0;
      check("mm_hex4", HEX4, GE);
      check("mm_busy", busy, 1'b1);
      upd_seen = 1'b0;
      for (int k = 1; k < ERRC; k++) begin
         tick();
         if (code_updated) upd_seen = 1'b1;
      end
      check("mm_busy_hold", busy, 1'b1);
      tick();
      check("mm_idle", busy, 1'b0);
      check("mm_hex4_idle", HEX4, BL);
      check("mm_code", code, 16'h2016);
      check("mm_no_upd", upd_seen, 1'b0);

      // program 4-5-1-9
      start();
      check("pg_busy", busy, 1'b1);
      check("pg_hex4_p", HEX4, GP);
      press(4); check("pg_hex3", HEX3, G4);
      press(5); check("pg_hex2", HEX2, G5);
      press(1); check("pg_hex1", HEX1, G1);
      press(9);
      check("pg_hex4_c", HEX4, GC);
      check("pg_blank", {HEX3, HEX2, HEX1, HEX0}, {4{BL}});
      press(4); check("pg_dash", HEX3, DS);
      press(5); press(1);
      sw = 10'd1 << 9;
      tick();
      sw = 10'd0;
      check("pg_code_lat", code, 16'h2016);
      check("pg_upd_lat", code_updated, 1'b0);
      tick();
      check("pg_code", code, 16'h4519);
      check("pg_upd", code_updated, 1'b1);
      check("pg_busy_done", busy, 1'b0);
      tick();
      check("pg_upd_pulse", code_updated, 1'b0);

      // press filtering
      start();
      sw = 10'b0000000101; tick();
      sw = 10'd0; tick();
      press(6);
      check("flt_multi_h3", HEX3, G6);
      check("flt_multi_h2", HEX2, BL);
      sw = 10'd1 << 3;
      for (int k = 0; k < 10; k++) tick();
      sw = 10'd0; tick();
      check("flt_hold_h2", HEX2, G3);
      check("flt_hold_h1", HEX1, BL);
      sw = 10'd1 << 3; tick();
      sw = 10'd1 << 7; tick();
      sw = 10'd0; tick();
      check("flt_nozero_h1", HEX1, G3);
      check("flt_nozero_h0", HEX0, BL);
      check("flt_still_p", HEX4, GP);
      for (int k = 0; k < 60; k++) begin
         if (busy) tick();
      end
      check("flt_back_idle", busy, 1'b0);

      // timeout after two digits
      start();
      press(2); press(0);
      for (int k = 0; k < 18; k++) tick();
      check("tmo_before", HEX4, GP);
      tick();
      check("tmo_err", HEX4, GE);
      for (int k = 1; k < ERRC; k++) tick();
      check("tmo_err_hold", busy, 1'b1);
      tick();
      check("tmo_idle", busy, 1'b0);
      check("tmo_code", code, 16'h4519);

      // asynchronous reset in the middle of confirmation
      start();
      press(7); press(3); press(8); press(2);
      press(7); press(3);
      #2 rst_n = 1'b0;
      #1;
      check("ar_code", code, 16'h2016);
      check("ar_busy", busy, 1'b0);
      check("ar_hex", {HEX4, HEX3, HEX2, HEX1, HEX0}, {5{BL}});
      rst_n = 1'b1;
      tick();
      start();
      press(5);
      check("ar_fresh_h3", HEX3, G5);
      check("ar_fresh_h2", HEX2, BL);
      check("ar_fresh_p", HEX4, GP);
      press(5); press(5); press(5);
      press(5); press(5); press(5); press(5);
      check("ar_code_new", code, 16'h5555);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
